// File: rtl/speed_tick_pkg.sv
// Purpose: shared constants for the speed tick scheduler: FSM encoding, levels, and prescaler thresholds.
// Latency: none. This file holds only constants and pure functions.
// Backpressure: none.
// Ports: none. The package is imported by speed_threshold_compare and speed_tick_scheduler.
package speed_tick_pkg;

    // FSM encoding. The states are plain constants so that legacy tools can consume them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_SWITCH = 2'd3;

    // Level values as they appear on the level output bus.
    localparam logic [2:0] LVL_2 = 3'd2;
    localparam logic [2:0] LVL_4 = 3'd4;
    localparam logic [2:0] LVL_6 = 3'd6;

    // Prescaler match values, defined at the native 23-bit width.
    localparam int          THR_W  = 23;
    localparam logic [22:0] THR_L2 = 23'h7FFFFF;
    localparam logic [22:0] THR_L4 = 23'h707C1E;
    localparam logic [22:0] THR_L6 = 23'h60F83D;

    // Any level code that is not recognised uses the slowest threshold.
    function automatic logic [22:0] level_threshold(input logic [2:0] level);
        case (level)
            LVL_4:   return THR_L4;
            LVL_6:   return THR_L6;
            default: return THR_L2;
        endcase
    endfunction

    // Advance the level by 2, saturating at level 6.
    function automatic logic [2:0] next_level(input logic [2:0] level);
        return (level >= LVL_4) ? LVL_6 : level + 3'd2;
    endfunction

endpackage

// File: rtl/speed_tick_scheduler_if.sv
// Purpose: groups the control inputs and the status outputs of the speed tick scheduler.
// Latency: none. This file contains wiring only.
// Backpressure: none. Every signal is a level or a pulse, and there is no handshake.
// Ports: master drives start/stop/pause/levelup and observes T0/level/tickcount/running.
//        slave is the scheduler side.
interface speed_tick_scheduler_if;
    logic       SPEED_TICK_SCHEDULER_start_In;
    logic       SPEED_TICK_SCHEDULER_stop_In;
    logic       SPEED_TICK_SCHEDULER_pause_In;
    logic       SPEED_TICK_SCHEDULER_levelup_In;
    logic       SPEED_TICK_SCHEDULER_T0_OutLow;
    logic [2:0] SPEED_TICK_SCHEDULER_level_OutBUS;
    logic [7:0] SPEED_TICK_SCHEDULER_tickcount_OutBUS;
    logic       SPEED_TICK_SCHEDULER_running_Out;

    modport master (
        output SPEED_TICK_SCHEDULER_start_In, SPEED_TICK_SCHEDULER_stop_In,
               SPEED_TICK_SCHEDULER_pause_In, SPEED_TICK_SCHEDULER_levelup_In,
        input  SPEED_TICK_SCHEDULER_T0_OutLow, SPEED_TICK_SCHEDULER_level_OutBUS,
               SPEED_TICK_SCHEDULER_tickcount_OutBUS, SPEED_TICK_SCHEDULER_running_Out
    );

    modport slave (
        input  SPEED_TICK_SCHEDULER_start_In, SPEED_TICK_SCHEDULER_stop_In,
               SPEED_TICK_SCHEDULER_pause_In, SPEED_TICK_SCHEDULER_levelup_In,
        output SPEED_TICK_SCHEDULER_T0_OutLow, SPEED_TICK_SCHEDULER_level_OutBUS,
               SPEED_TICK_SCHEDULER_tickcount_OutBUS, SPEED_TICK_SCHEDULER_running_Out
    );
endinterface

// File: rtl/speed_threshold_compare.sv
// Purpose: compares the prescaler against the threshold for the current level and returns an active-low match.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: prescaler_i is the DATAWIDTH-bit count, level_i is the current level code, and match_n_o is low on a match.
module speed_threshold_compare
    import speed_tick_pkg::*;
#(
    parameter int DATAWIDTH = 23
) (
    input  logic [DATAWIDTH-1:0] prescaler_i,
    input  logic [2:0]           level_i,
    output logic                 match_n_o
);

    // A prescaler narrower than 23 bits keeps the top bits of each threshold.
    // This preserves the relative tick rates of the levels in reduced-width builds.
    // A wider prescaler simply zero-extends the threshold.
    localparam int SH = (DATAWIDTH < THR_W) ? (THR_W - DATAWIDTH) : 0;

    assign match_n_o = ~(prescaler_i == DATAWIDTH'(level_threshold(level_i) >> SH));

endmodule

// File: rtl/speed_tick_scheduler.sv
// Purpose: game-speed tick generator. It has levels 2/4/6, and it supports pause, stop, and level advance.
// Latency: T0 goes low for one cycle, on the cycle after the prescaler matches the threshold. The tick period is threshold+1.
// Backpressure: none. Commands are sampled every cycle with priority stop > pause > levelup > start.
// Ports: SPEED_TICK_SCHEDULER_CLOCK_50 is the clock, SPEED_TICK_SCHEDULER_RESET_InLow is the async active-low reset,
//        and bus (speed_tick_scheduler_if.slave) carries the commands and status.
// Option: defining SPEED_TICK_SCHEDULER_AUTOLEVEL_EN makes the block advance a level after TICKS_PER_LEVEL ticks.
module speed_tick_scheduler
    import speed_tick_pkg::*;
#(
    parameter int DATAWIDTH       = 23,
    parameter int TICKS_PER_LEVEL = 256
) (
    input logic                    SPEED_TICK_SCHEDULER_CLOCK_50,
    input logic                    SPEED_TICK_SCHEDULER_RESET_InLow,
    speed_tick_scheduler_if.slave  bus
);

`ifdef SPEED_TICK_SCHEDULER_AUTOLEVEL_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] presc_q, presc_d;
    logic [2:0]           level_q, level_d;
    logic [7:0]           tcnt_q, tcnt_d;
    logic                 t0_n_q, t0_n_d;
    logic                 match_n;
    logic                 auto_lvl;

    logic start_i, stop_i, pause_i, levelup_i;
    assign start_i   = bus.SPEED_TICK_SCHEDULER_start_In;
    assign stop_i    = bus.SPEED_TICK_SCHEDULER_stop_In;
    assign pause_i   = bus.SPEED_TICK_SCHEDULER_pause_In;
    assign levelup_i = bus.SPEED_TICK_SCHEDULER_levelup_In;

    speed_threshold_compare #(.DATAWIDTH(DATAWIDTH)) u_cmp (
        .prescaler_i (presc_q),
        .level_i     (level_q),
        .match_n_o   (match_n)
    );

    // The match that produces the TICKS_PER_LEVEL-th tick also requests a level change.
    // The level change then behaves like a levelup pulse that coincides with a tick.
    assign auto_lvl = AUTO_EN && !match_n &&
                      ((32'(tcnt_q) + 32'd1) == 32'(TICKS_PER_LEVEL));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        level_d = level_q;
        tcnt_d  = tcnt_q;
        t0_n_d  = 1'b1;
        if (stop_i) begin
            // Stop overrides everything else. The level is deliberately kept.
            state_d = ST_IDLE;
            presc_d = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    // Pause outranks start, so a held pause keeps the block idle.
                    if (start_i && !pause_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // The tick is always serviced here, even when the state also changes on this edge.
                    if (!match_n) begin
                        t0_n_d  = 1'b0;
                        presc_d = '0;
                        if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    end else begin
                        presc_d = presc_q + DATAWIDTH'(1);
                    end
                    if (pause_i)                    state_d = ST_PAUSED;
                    else if (levelup_i || auto_lvl) state_d = ST_SWITCH;
                end
                ST_PAUSED: begin
                    if (!pause_i) state_d = ST_RUN;
                end
                ST_SWITCH: begin
                    level_d = next_level(level_q);
                    presc_d = '0;
                    tcnt_d  = '0;
                    state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SPEED_TICK_SCHEDULER_CLOCK_50 or negedge SPEED_TICK_SCHEDULER_RESET_InLow) begin
        if (!SPEED_TICK_SCHEDULER_RESET_InLow) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            level_q <= LVL_2;
            tcnt_q  <= '0;
            t0_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            level_q <= level_d;
            tcnt_q  <= tcnt_d;
            t0_n_q  <= t0_n_d;
        end
    end

    assign bus.SPEED_TICK_SCHEDULER_T0_OutLow        = t0_n_q;
    assign bus.SPEED_TICK_SCHEDULER_level_OutBUS     = level_q;
    assign bus.SPEED_TICK_SCHEDULER_tickcount_OutBUS = tcnt_q;
    assign bus.SPEED_TICK_SCHEDULER_running_Out      = (state_q == ST_RUN);

endmodule

// File: doc/speed_tick_scheduler.md
SPEED_TICK_SCHEDULER -- requirements
Module: speed_tick_scheduler

Interface
REQ-001 Parameter DATAWIDTH, default 23, SHALL set prescaler counter width.
REQ-002 Parameter TICKS_PER_LEVEL, default 256, SHALL set ticks before an automatic level advance.
REQ-003 SPEED_TICK_SCHEDULER_CLOCK_50 input 1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 SPEED_TICK_SCHEDULER_RESET_InLow input 1: SHALL be the asynchronous, active-low reset.
REQ-005 SPEED_TICK_SCHEDULER_start_In input 1: SHALL request the start of tick generation.
REQ-006 SPEED_TICK_SCHEDULER_stop_In input 1: SHALL request a return to idle.
REQ-007 SPEED_TICK_SCHEDULER_pause_In input 1: SHALL hold the schedule while high.
REQ-008 SPEED_TICK_SCHEDULER_levelup_In input 1: SHALL request a level advance on a single-cycle pulse.
REQ-009 SPEED_TICK_SCHEDULER_T0_OutLow output 1: SHALL be an active-low game-tick strobe.
REQ-010 SPEED_TICK_SCHEDULER_level_OutBUS output 3: SHALL carry the current level (2, 4 or 6).
REQ-011 SPEED_TICK_SCHEDULER_tickcount_OutBUS output 8: SHALL carry the ticks counted in the current level.
REQ-012 SPEED_TICK_SCHEDULER_running_Out output 1: SHALL be high only in state RUN.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSED and SWITCH.
REQ-014 Transitions SHALL be: IDLE->RUN on start; RUN->PAUSED on pause; PAUSED->RUN on pause low; RUN->SWITCH on levelup; SWITCH->RUN unconditionally after 1 cycle.
REQ-015 Input priority SHALL be stop > pause > levelup > start; stop SHALL force IDLE from any state on the next edge.
REQ-016 The prescaler SHALL increment by 1 per cycle in RUN only, and SHALL hold its value in PAUSED.
REQ-017 Thresholds SHALL be: level 2 = 23'h7FFFFF, level 4 = 23'h707C1E, level 6 = 23'h60F83D; any other level value SHALL use 23'h7FFFFF.
REQ-018 When prescaler == threshold in RUN, T0_OutLow SHALL be low for exactly the next cycle, the prescaler SHALL clear to 0, and tickcount SHALL increment.
REQ-019 Tick period SHALL therefore be threshold+1 cycles; the prescaler SHALL never wrap past all-ones.
REQ-020 tickcount SHALL saturate at 255.
REQ-021 In SWITCH, level SHALL step +2 and saturate at 6, the prescaler SHALL clear, and tickcount SHALL clear.
REQ-022 If a threshold match and levelup occur in the same cycle, the tick SHALL be emitted first and SWITCH SHALL follow.
REQ-023 Entering IDLE via stop SHALL clear the prescaler and tickcount and SHALL retain the level.
REQ-024 levelup in IDLE or PAUSED SHALL be ignored.

Reset
REQ-025 Reset assertion SHALL immediately force state IDLE, prescaler 0, level 2, tickcount 0, T0_OutLow 1 and running_Out 0, including mid-tick or mid-SWITCH.
REQ-026 After reset release, the first state change SHALL occur on the first clock edge at which start is sampled high.

Configuration
REQ-027 With SPEED_TICK_SCHEDULER_AUTOLEVEL_EN defined, reaching TICKS_PER_LEVEL ticks in RUN SHALL enter SWITCH exactly as a levelup pulse does.
REQ-028 Without SPEED_TICK_SCHEDULER_AUTOLEVEL_EN, the level SHALL change only via levelup_In.

Structure
REQ-029 Package speed_tick_pkg SHALL hold the state encoding, the level constants (2/4/6) and the three threshold constants.
REQ-030 The threshold compare SHALL be sub-module speed_threshold_compare, taking prescaler and level and returning an active-low match.

Verification
REQ-031 Reset, start, level 2: T0_OutLow SHALL first go low 8388608 cycles after entry to RUN; tickcount SHALL become 1.
REQ-032 levelup pulse in RUN: SHALL produce one SWITCH cycle; level SHALL be 4, prescaler and tickcount SHALL be 0, and the next tick SHALL come 7371807 cycles later.
REQ-033 Three levelups: level SHALL end at 6 and not exceed it; tick period SHALL be 6355006 cycles.
REQ-034 Pause held for 1000 cycles mid-count: tick SHALL be delayed by exactly 1000 cycles; stop plus pause together SHALL give IDLE.
REQ-035 Reset asserted one cycle after a match: all outputs SHALL reach reset values without waiting for a clock edge; level SHALL be 2.
REQ-036 AUTOLEVEL_EN with TICKS_PER_LEVEL=2: two ticks SHALL be followed by SWITCH and level 4; with the macro undefined, level SHALL remain 2.
